// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
//   Fetch-stage program counter with stall, sticky halt, branch redirect and
//   call/return through a small circular return-address stack (RAS).
//
//   Parameters
//     WIDTH        PC width in bits; all PC arithmetic wraps modulo 2^WIDTH
//     RESET_VECTOR PC value loaded by reset
//     INC          sequential increment
//     RAS_DEPTH    return-stack entries (power of two, >= 2)
//
//   Ports
//     clk, rst       clock and synchronous active-high reset
//     stall          freeze PC, RAS and flags this cycle
//     halt           freeze PC and set the sticky halted flag
//     branch_en      redirect to branch_target
//     call_en        push pc_plus, redirect to call_target
//     ret_en         pop RAS top into pc
//     pc             registered fetch PC
//     pc_plus        combinational pc + INC
//     halted         registered sticky halt status (cleared only by rst)
//     ras_empty      RAS holds no entries
//     ras_full       RAS holds RAS_DEPTH entries
//     ras_overflow   sticky: a push happened while full
//     ras_underflow  sticky: a pop happened while empty
//
//   Edge priority (first match wins, losers are dropped):
//     rst > halted > stall > halt > branch_en > ret_en > call_en > sequential
// ----------------------------------------------------------------------------
module pc_unit #(
  parameter int unsigned       WIDTH        = 16,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       INC          = 2,
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             call_en,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_ptr;   // index of the most recent entry
  logic [CW-1:0]    count;
  logic [PW-1:0]    push_ptr;

  logic active;
  logic do_halt;
  logic do_branch;
  logic do_ret;
  logic do_call;

  assign pc_plus   = pc + WIDTH'(INC);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));
  // Power-of-two depth lets the pointer wrap naturally; a push while full
  // lands on the oldest entry, which is exactly the circular overwrite.
  assign push_ptr  = top_ptr + PW'(1);

  // One-hot decode of the winning request for this edge.
  always_comb begin
    active    = !rst && !halted && !stall;
    do_halt   = active && halt;
    do_branch = active && !halt && branch_en;
    do_ret    = active && !halt && !branch_en && ret_en;
    do_call   = active && !halt && !branch_en && !ret_en && call_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_VECTOR;
      halted        <= 1'b0;
      top_ptr       <= '0;
      count         <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else if (active) begin
      if (do_halt) begin
        halted <= 1'b1;
      end else if (do_branch) begin
        pc <= branch_target;
      end else if (do_ret) begin
        if (!ras_empty) begin
          pc      <= ras_mem[top_ptr];
          top_ptr <= top_ptr - PW'(1);
          count   <= count - CW'(1);
        end else begin
          pc            <= pc_plus;
          ras_underflow <= 1'b1;
        end
      end else if (do_call) begin
        pc      <= call_target;
        top_ptr <= push_ptr;
        if (!ras_full) begin
          count <= count + CW'(1);
        end else begin
          ras_overflow <= 1'b1;
        end
      end else begin
        pc <= pc_plus;
      end
    end
  end

  // Storage is not reset: entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (do_call) begin
      ras_mem[push_ptr] <= pc_plus;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_unit
//   Directed table of hand-derived vectors, hand-written RAS bound and
//   mid-operation reset sequences, then randomized traffic compared against
//   a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_pc_unit;

  localparam int          WIDTH = 16;
  localparam logic [15:0] RV    = 16'h0100;
  localparam int          INC   = 2;
  localparam int          DEPTH = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, halt, branch_en, call_en, ret_en;
  logic [15:0] branch_target, call_target;
  logic [15:0] pc, pc_plus;
  logic        halted, ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_unit #(
    .WIDTH(WIDTH), .RESET_VECTOR(RV), .INC(INC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_target(branch_target),
    .call_en(call_en), .call_target(call_target), .ret_en(ret_en),
    .pc(pc), .pc_plus(pc_plus), .halted(halted),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  int checks = 0;
  int errors = 0;

  // reference model: return addresses kept in a queue, newest at the back
  int unsigned m_pc;
  bit          m_halted, m_ovf, m_unf;
  logic [15:0] m_ras[$];

  function automatic void model_step(bit r, bit s, bit h, bit b, logic [15:0] bt,
                                     bit c, logic [15:0] ct, bit rt);
    if (r) begin
      m_pc = RV; m_halted = 0; m_ovf = 0; m_unf = 0; m_ras.delete();
    end else if (m_halted || s) begin
      // everything holds
    end else if (h) begin
      m_halted = 1;
    end else if (b) begin
      m_pc = bt;
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = (m_pc + INC) % 65536; m_unf = 1; end
    end else if (c) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1;
      end
      m_ras.push_back(16'((m_pc + INC) % 65536));
      m_pc = ct;
    end else begin
      m_pc = (m_pc + INC) % 65536;
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " pc"},        32'(pc),            32'(m_pc));
    chk({tag, " pc_plus"},   32'(pc_plus),       (m_pc + INC) % 65536);
    chk({tag, " halted"},    32'(halted),        32'(m_halted));
    chk({tag, " empty"},     32'(ras_empty),     32'(m_ras.size() == 0));
    chk({tag, " full"},      32'(ras_full),      32'(m_ras.size() == DEPTH));
    chk({tag, " overflow"},  32'(ras_overflow),  32'(m_ovf));
    chk({tag, " underflow"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  // driver: apply inputs, clock once, advance model, compare just after edge
  task automatic step(string tag, bit r, bit s, bit h, bit b, logic [15:0] bt,
                      bit c, logic [15:0] ct, bit rt);
    rst = r; stall = s; halt = h; branch_en = b; branch_target = bt;
    call_en = c; call_target = ct; ret_en = rt;
    @(posedge clk);
    model_step(r, s, h, b, bt, c, ct, rt);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit r, s, h, b; logic [15:0] bt;
    bit c; logic [15:0] ct; bit rt;
    logic [15:0] e_pc; bit e_halted, e_empty, e_full;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit h, bit b, logic [15:0] bt, bit c,
                              logic [15:0] ct, bit rt, logic [15:0] e_pc,
                              bit e_halted, bit e_empty, bit e_full);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.b = b; v.bt = bt; v.c = c; v.ct = ct; v.rt = rt;
    v.e_pc = e_pc; v.e_halted = e_halted; v.e_empty = e_empty; v.e_full = e_full;
    return v;
  endfunction

  task automatic expect_io(string tag, logic [15:0] e_pc, bit e_h, bit e_em,
                           bit e_fu, bit e_ov, bit e_un);
    chk({tag, " pc"},        32'(pc),            32'(e_pc));
    chk({tag, " halted"},    32'(halted),        32'(e_h));
    chk({tag, " empty"},     32'(ras_empty),     32'(e_em));
    chk({tag, " full"},      32'(ras_full),      32'(e_fu));
    chk({tag, " overflow"},  32'(ras_overflow),  32'(e_ov));
    chk({tag, " underflow"}, 32'(ras_underflow), 32'(e_un));
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; stall = 0; halt = 0; branch_en = 0; call_en = 0; ret_en = 0;
    branch_target = '0; call_target = '0;
    m_pc = 0; m_halted = 0; m_ovf = 0; m_unf = 0;

    //             r s h b bt       c ct       rt   pc       h em fu
    tbl.push_back(mk(1,0,0,0,16'h0000,0,16'h0000,0, 16'h0100,0,1,0)); // reset
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0, 16'h0102,0,1,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0, 16'h0104,0,1,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,0,16'h0000,0, 16'h0104,0,1,0)); // stall x3
    tbl.push_back(mk(0,1,0,1,16'h0999,0,16'h0000,0, 16'h0104,0,1,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,1,16'h0888,0, 16'h0104,0,1,0));
    tbl.push_back(mk(0,0,0,1,16'h0010,0,16'h0000,0, 16'h0010,0,1,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h0200,0, 16'h0200,0,0,0)); // call
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,1, 16'h0012,0,1,0)); // ret
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h0400,0, 16'h0400,0,0,0));
    tbl.push_back(mk(0,0,0,1,16'h0300,1,16'h0600,1, 16'h0300,0,0,0)); // br wins
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h0700,1, 16'h0014,0,1,0)); // pop only
    tbl.push_back(mk(0,0,0,1,16'hFFFE,0,16'h0000,0, 16'hFFFE,0,1,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0, 16'h0000,0,1,0)); // wrap
    tbl.push_back(mk(0,0,1,0,16'h0000,0,16'h0000,0, 16'h0000,1,1,0)); // halt
    tbl.push_back(mk(0,0,0,1,16'h0500,0,16'h0000,0, 16'h0000,1,1,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h0700,1, 16'h0000,1,1,0));
    tbl.push_back(mk(1,0,0,0,16'h0000,0,16'h0000,0, 16'h0100,0,1,0)); // rst
    tbl.push_back(mk(0,1,1,0,16'h0000,0,16'h0000,0, 16'h0100,0,1,0)); // halt under stall
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000,0, 16'h0102,0,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tag, tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].b, tbl[i].bt,
           tbl[i].c, tbl[i].ct, tbl[i].rt);
      expect_io(tag, tbl[i].e_pc, tbl[i].e_halted, tbl[i].e_empty, tbl[i].e_full, 0, 0);
    end

    // RAS bounds: five nested calls at depth 4, then five returns
    step("t5 rst", 1,0,0,0,16'h0,0,16'h0,0);
    for (int i = 1; i <= 5; i++)
      step("t5 call", 0,0,0,0,16'h0,1,16'(i * 16'h1000),0);
    expect_io("t5 after calls", 16'h5000, 0, 0, 1, 1, 0);
    step("t5 ret1", 0,0,0,0,16'h0,0,16'h0,1);
    expect_io("t5 ret1", 16'h4002, 0, 0, 0, 1, 0);
    step("t5 ret2", 0,0,0,0,16'h0,0,16'h0,1);
    expect_io("t5 ret2", 16'h3002, 0, 0, 0, 1, 0);
    step("t5 ret3", 0,0,0,0,16'h0,0,16'h0,1);
    expect_io("t5 ret3", 16'h2002, 0, 0, 0, 1, 0);
    step("t5 ret4", 0,0,0,0,16'h0,0,16'h0,1);
    expect_io("t5 ret4", 16'h1002, 0, 1, 0, 1, 0);
    step("t5 ret5", 0,0,0,0,16'h0,0,16'h0,1);
    expect_io("t5 ret5", 16'h1004, 0, 1, 0, 1, 1);

    // reset mid-operation with three entries stacked and flags set
    for (int i = 0; i < 3; i++)
      step("t6 call", 0,0,0,0,16'h0,1,16'(16'h2000 + i * 16'h10),0);
    expect_io("t6 before rst", 16'h2020, 0, 0, 0, 1, 1);
    step("t6 rst", 1,0,0,1,16'h0ABC,1,16'h0DEF,1);
    expect_io("t6 rst", 16'h0100, 0, 1, 0, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($sformatf("rnd%0d", i),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom_range(0, 32767) * 2),
           ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 32767) * 2),
           ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
